// File: rtl/wfg_timer_multi_pkg.sv
// Shared definitions for the multi-channel Wishbone timer: register map,
// CTRL bit layout and the bus-side state encoding.
package wfg_timer_multi_pkg;

  // Per-channel register offsets (channel c lives at c*0x10 + offset).
  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_PRESCALE   = 8'h04;
  localparam logic [7:0] OFF_COMPARE    = 8'h08;
  localparam logic [7:0] OFF_COUNT      = 8'h0C;

  // Global pending register, write-1-to-clear.
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h80;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;
  localparam int CTRL_W           = 3;

  // CTRL register image; field order matches the bit positions above.
  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;

  // Wishbone slave handshake state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/wfg_timer_channel.sv
// One timer channel: prescaler, up-counter, compare register and a sticky
// pending flag. Register writes arrive as decoded single-cycle strobes.
module wfg_timer_channel
  import wfg_timer_multi_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_we,
  input  logic                 psc_we,
  input  logic                 cmp_we,
  input  logic                 cnt_we,
  input  logic                 w1c,
  input  logic [31:0]          wdata,
  output logic [CTRL_W-1:0]    ctrl,
  output logic [PSC_WIDTH-1:0] prescale,
  output logic [CNT_WIDTH-1:0] compare,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 pending
);

  localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  ctrl_t                ctrl_q;
  ctrl_t                ctrl_wr;
  logic [PSC_WIDTH-1:0] prescale_q;
  logic [PSC_WIDTH-1:0] psc_cnt_q;
  logic [CNT_WIDTH-1:0] compare_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 pending_q;

  logic en_rise;   // CTRL write turning the channel on
  logic en_drop;   // CTRL write leaving the channel off
  logic tick;      // prescaler wrapped this cycle
  logic tick_eff;  // tick that is allowed to touch COUNT
  logic match;     // effective tick with COUNT == COMPARE

  assign ctrl_wr  = wdata[CTRL_W-1:0];
  assign en_rise  = ctrl_we & ctrl_wr.en & ~ctrl_q.en;
  assign en_drop  = ctrl_we & ~ctrl_wr.en;
  assign tick     = ctrl_q.en & (psc_cnt_q == prescale_q);
  // A COUNT write or a disabling CTRL write in the same cycle suppresses the tick.
  assign tick_eff = tick & ~en_drop & ~cnt_we;
  assign match    = tick_eff & (count_q == compare_q);

  // CTRL: bus write wins; a one-shot match drops en by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (ctrl_we) begin
      ctrl_q <= ctrl_wr;
    end else if (match && ctrl_q.oneshot) begin
      ctrl_q.en <= 1'b0;
    end
  end

  // PRESCALE and COMPARE are plain bus-written registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      compare_q  <= '0;
    end else begin
      if (psc_we) prescale_q <= wdata[PSC_WIDTH-1:0];
      if (cmp_we) compare_q  <= wdata[CNT_WIDTH-1:0];
    end
  end

  // Prescaler: counts 0..PRESCALE while enabled, restarted by register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt_q <= '0;
    end else if (psc_we || cnt_we || en_rise) begin
      psc_cnt_q <= '0;
    end else if (ctrl_q.en && !en_drop) begin
      psc_cnt_q <= tick ? '0 : psc_cnt_q + PSC_ONE;
    end
  end

  // Counter: load from bus, clear on enable, advance or restart on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (cnt_we) begin
      count_q <= wdata[CNT_WIDTH-1:0];
    end else if (en_rise) begin
      count_q <= '0;
    end else if (tick_eff) begin
      count_q <= match ? '0 : count_q + CNT_ONE;
    end
  end

  // Pending: a new match beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (match) begin
      pending_q <= 1'b1;
    end else if (w1c) begin
      pending_q <= 1'b0;
    end
  end

  assign ctrl     = ctrl_q;
  assign prescale = prescale_q;
  assign compare  = compare_q;
  assign count    = count_q;
  assign pending  = pending_q;

endmodule

// File: rtl/wfg_timer_multi.sv
// Multi-channel Wishbone timer. Bus handshake: a request is stb & cyc seen
// while the slave is idle; wbs_ack_o is registered and high for exactly the
// following cycle, writes commit and read data is captured on that same edge,
// and a strobe held through ack is serviced again one cycle later.
module wfg_timer_multi
  import wfg_timer_multi_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int PSC_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              interrupt_o
);

  bus_state_t           state_q;
  bus_state_t           state_d;
  logic [5:0]           word;
  logic                 req;
  logic                 wr_en;
  logic                 irq_status_hit;
  logic [31:0]          rd_data;
  logic [31:0]          dat_q;
  logic [NUM_CH-1:0]    pending_vec;
  logic [NUM_CH-1:0]    irq_en_vec;
  logic [NUM_CH-1:0]    irq_q;
  logic [CTRL_W-1:0]    ctrl_a [NUM_CH];
  logic [PSC_WIDTH-1:0] psc_a  [NUM_CH];
  logic [CNT_WIDTH-1:0] cmp_a  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_a  [NUM_CH];
  logic                 unused_adr_bits;

  // Only byte-address bits [7:2] select a register.
  assign word            = wbs_adr_i[7:2];
  assign unused_adr_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign req            = wbs_stb_i & wbs_cyc_i & (state_q == ST_IDLE);
  assign wr_en          = req & wbs_we_i;
  assign irq_status_hit = (word == OFF_IRQ_STATUS[7:2]);

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Bus FSM next state: one ack cycle per accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = (state_q == ST_ACK);

  // Read mux: unmapped offsets and absent channels read as zero.
  always_comb begin
    rd_data = '0;
    if (irq_status_hit) rd_data = 32'(pending_vec);
    for (int c = 0; c < NUM_CH; c++) begin
      if (word[5:2] == 4'(c)) begin
        case (word[1:0])
          OFF_CTRL[3:2]:     rd_data = 32'(ctrl_a[c]);
          OFF_PRESCALE[3:2]: rd_data = 32'(psc_a[c]);
          OFF_COMPARE[3:2]:  rd_data = 32'(cmp_a[c]);
          OFF_COUNT[3:2]:    rd_data = 32'(cnt_a[c]);
          default:           rd_data = '0;
        endcase
      end
    end
  end

  // Read data is registered alongside ack and returns to zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dat_q <= '0;
    else        dat_q <= (req && !wbs_we_i) ? rd_data : '0;
  end

  assign wbs_dat_o = dat_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en & (word[5:2] == 4'(c));

    wfg_timer_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .PSC_WIDTH (PSC_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl_we  (ch_wr & (word[1:0] == OFF_CTRL[3:2])),
      .psc_we   (ch_wr & (word[1:0] == OFF_PRESCALE[3:2])),
      .cmp_we   (ch_wr & (word[1:0] == OFF_COMPARE[3:2])),
      .cnt_we   (ch_wr & (word[1:0] == OFF_COUNT[3:2])),
      .w1c      (wr_en & irq_status_hit & wbs_dat_i[c]),
      .wdata    (wbs_dat_i),
      .ctrl     (ctrl_a[c]),
      .prescale (psc_a[c]),
      .compare  (cmp_a[c]),
      .count    (cnt_a[c]),
      .pending  (pending_vec[c])
    );

    assign irq_en_vec[c] = ctrl_a[c][CTRL_IRQ_EN_BIT];
  end

  // Interrupt outputs are registered one cycle behind pending/irq_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= pending_vec & irq_en_vec;
  end

  assign irq_o       = irq_q;
  assign interrupt_o = |irq_q;

endmodule
